// File: rtl/first_nios2_system_sysid_checker_pkg.sv
// Shared definitions for the system-ID checker: FSM encoding, word addresses
// and the counter-width helper used to size the timeout and period counters.
package sysid_checker_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    RD_TS  = 3'd2,
    FINISH = 3'd3,
    WAIT   = 3'd4
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/first_nios2_system_sysid_timeout.sv
// Loadable down-counter. 'expired' flags the enabled tick that consumes the last
// count, so a load of N expires on the N-th enabled cycle after the load.
module first_nios2_system_sysid_timeout #(
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  assign expired = enable && !load && (count_q == WIDTH'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and compares
// them with build-time values. Define SYSID_CHECKER_PERIODIC_EN for automatic rechecks.
module first_nios2_system_sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h56DC_7A6F,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          AUTO_START     = 1,
  parameter int          PERIOD_CYCLES  = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        err_id,
  output logic        err_ts,
  output logic        err_timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int              TO_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES < 1 || PERIOD_CYCLES < 2) begin : g_bad_cfg
      $error("sysid checker: TIMEOUT_CYCLES must be >= 1 and PERIOD_CYCLES >= 2");
    end
  endgenerate

  state_e      state_q, state_d;
  logic        first_cycle_q, first_cycle_d;
  logic        pass_q, pass_d;
  logic        err_id_q, err_id_d;
  logic        err_ts_q, err_ts_d;
  logic        err_to_q, err_to_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;

  logic        to_load;
  logic        to_enable;
  logic        to_expired;
  logic        period_expired;
  logic        launch;

  first_nios2_system_sysid_timeout #(
    .WIDTH (TO_W)
  ) u_read_timeout (
    .clock      (clock),
    .reset      (reset),
    .load       (to_load),
    .load_value (TO_LOAD),
    .enable     (to_enable),
    .expired    (to_expired)
  );

`ifdef SYSID_CHECKER_PERIODIC_EN
  localparam int              PER_W    = cnt_width(PERIOD_CYCLES);
  localparam logic [PER_W-1:0] PER_LOAD = PER_W'(PERIOD_CYCLES);
  localparam state_e          REST     = WAIT;

  first_nios2_system_sysid_timeout #(
    .WIDTH (PER_W)
  ) u_period (
    .clock      (clock),
    .reset      (reset),
    .load       (state_q == FINISH),
    .load_value (PER_LOAD),
    .enable     (state_q == WAIT),
    .expired    (period_expired)
  );
`else
  localparam state_e REST = IDLE;
  assign period_expired = 1'b0;
`endif

  // The auto-start request exists only in the first cycle after reset release.
  assign launch = start || ((AUTO_START != 0) && first_cycle_q);

  always_comb begin
    state_d       = state_q;
    first_cycle_d = 1'b0;
    pass_d        = pass_q;
    err_id_d      = err_id_q;
    err_ts_d      = err_ts_q;
    err_to_d      = err_to_q;
    id_d          = id_q;
    ts_d          = ts_q;
    to_load       = 1'b0;
    to_enable     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = SYSID_ADDR_ID;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_q)
      IDLE, WAIT: begin
        if (launch || ((state_q == WAIT) && period_expired)) begin
          state_d  = RD_ID;
          to_load  = 1'b1;
          pass_d   = 1'b0;
          err_id_d = 1'b0;
          err_ts_d = 1'b0;
          err_to_d = 1'b0;
        end
      end
      RD_ID: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = SYSID_ADDR_ID;
        if (!avm_waitrequest) begin
          id_d     = avm_readdata;
          err_id_d = (avm_readdata != EXPECTED_ID);
          to_load  = 1'b1;
          state_d  = RD_TS;
        end else begin
          to_enable = 1'b1;
          if (to_expired) begin
            err_to_d = 1'b1;
            state_d  = FINISH;
          end
        end
      end
      RD_TS: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = SYSID_ADDR_TS;
        if (!avm_waitrequest) begin
          ts_d     = avm_readdata;
          err_ts_d = (avm_readdata != EXPECTED_TS);
          // Verdict is registered on entry to FINISH so it appears alongside done.
          pass_d   = !(err_id_q || (avm_readdata != EXPECTED_TS));
          state_d  = FINISH;
        end else begin
          to_enable = 1'b1;
          if (to_expired) begin
            err_to_d = 1'b1;
            state_d  = FINISH;
          end
        end
      end
      FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = REST;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      first_cycle_q <= 1'b1;
      pass_q        <= 1'b0;
      err_id_q      <= 1'b0;
      err_ts_q      <= 1'b0;
      err_to_q      <= 1'b0;
      id_q          <= '0;
      ts_q          <= '0;
    end else begin
      state_q       <= state_d;
      first_cycle_q <= first_cycle_d;
      pass_q        <= pass_d;
      err_id_q      <= err_id_d;
      err_ts_q      <= err_ts_d;
      err_to_q      <= err_to_d;
      id_q          <= id_d;
      ts_q          <= ts_d;
    end
  end

  assign pass        = pass_q;
  assign err_id      = err_id_q;
  assign err_ts      = err_ts_q;
  assign err_timeout = err_to_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule
